// File: rtl/dmem_lsu.sv
// dmem_lsu: byte/half/word load-store unit driving a single-port word-wide data memory
module dmem_lsu #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);
  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;
  state_t state, state_n;
  logic              we_q, uns_q, bad, accept;
  logic [1:0]        size_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       din_q, lane, load_val, mask, merged;
  logic [4:0]        sh;
  logic              unused_addr;
  // the word address wraps: bits above the dmem range are dropped
  assign unused_addr = ^req_addr[31:ADDR_W+2];
  assign accept = req_valid && req_ready;
  assign bad = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]) ||
               (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign req_ready = state == IDLE && !rst;
  assign resp_valid = state == RESP && !rst;
  assign mem_we = state == WR && !rst;
  assign mem_addr = addr_q[ADDR_W+1:2];
  assign mem_din = din_q;
  always_comb begin
    sh = size_q == 2'b01 ? {addr_q[1], 4'b0} : {addr_q[1:0], 3'b0};
    lane = mem_dout >> sh;
    load_val = size_q == 2'b00 ? {{24{lane[7] & ~uns_q}}, lane[7:0]} :
               size_q == 2'b01 ? {{16{lane[15] & ~uns_q}}, lane[15:0]} : lane;
    mask = (size_q == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << sh;
    merged = (mem_dout & ~mask) | ((din_q << sh) & mask);
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = !accept ? IDLE : bad ? RESP :
                      (req_we && req_size == 2'b10) ? WR : RD;
      RD:   state_n = WAIT;
      WAIT: state_n = we_q ? WR : RESP;
      WR:   state_n = RESP;
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= '0;
      din_q      <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        we_q   <= req_we;
        uns_q  <= req_unsigned;
        size_q <= req_size;
        addr_q <= req_addr[ADDR_W+1:0];
        din_q  <= req_wdata;
        if (bad) begin
          resp_rdata <= '0;
          resp_err   <= 1'b1;
        end
      end
      // WAIT holds the freshly read word: merge it for stores, format it for loads
      if (state == WAIT && we_q) din_q <= merged;
      if (state == WAIT && !we_q) begin
        resp_rdata <= load_val;
        resp_err   <= 1'b0;
      end
      if (state == WR) begin
        resp_rdata <= '0;
        resp_err   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed table, reset corner case and random traffic against a word-array model
module tb_dmem_lsu;
  logic        clk, rst, clr;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_din, mem_dout;
  logic [31:0] mem [0:4095];
  logic [31:0] model [0:4095];
  int pass_cnt = 0, total_cnt = 0;

  dmem_lsu #(.ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_din;
      mem_dout <= mem[mem_addr];
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] a, wd, rd;
    logic        er;
    int          lat;
    logic [31:0] din;
    logic [11:0] wadr;
  } vec_t;
  vec_t tv [18];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h", n, act, exp);
  endtask

  task automatic model_step(input logic we, input logic [1:0] sz, input logic un,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output logic er, output int lat,
                            output logic [31:0] din, output logic [11:0] idx);
    int nb, sh;
    logic [31:0] w, m;
    idx = a[13:2];
    nb = 1 << sz;
    sh = 8 * int'(a[1:0]);
    m = (nb == 4) ? 32'hffff_ffff : ((32'h1 << (8 * nb)) - 1);
    er = sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    rd = 0;
    din = 0;
    w = model[idx];
    if (er) lat = 1;
    else if (!we) begin
      rd = (w >> sh) & m;
      if (!un && nb < 4 && rd[8*nb-1]) rd = rd | ~m;
      lat = 3;
    end else begin
      model[idx] = (w & ~(m << sh)) | ((wd & m) << sh);
      din = model[idx];
      lat = (nb == 4) ? 2 : 4;
    end
  endtask

  task automatic do_txn(input logic we, input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] e_rd, input logic e_er, input int e_lat,
                        input logic [31:0] e_din, input logic [11:0] e_wadr);
    logic [31:0] rd, wdin;
    logic [11:0] wadr;
    logic er, ok;
    int lat, wes;
    rd = 0; er = 0; wdin = 0; wadr = 0; ok = 0; lat = 0; wes = 0;
    @(negedge clk);
    chk("ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1; req_we = we; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 0;
    for (int i = 1; i <= 8; i++) begin
      if (mem_we) begin
        wes++;
        wdin = mem_din;
        wadr = mem_addr;
      end
      if (resp_valid) begin
        lat = i; rd = resp_rdata; er = resp_err; ok = 1;
        break;
      end
      chk("ready_busy", {31'b0, req_ready}, 32'd0);
      // requests presented while busy must be ignored
      req_valid = 1'($urandom_range(0, 1));
      req_we = 1'($urandom); req_size = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
      @(negedge clk);
    end
    req_valid = 0;
    if (!ok) begin
      total_cnt++;
      $display("FAIL resp_timeout actual=none required=resp_valid within 8 cycles");
    end else begin
      chk("resp_rdata", rd, e_rd);
      chk("resp_err", {31'b0, er}, {31'b0, e_er});
      chk("latency", lat, e_lat);
      chk("write_count", wes, (we && !e_er) ? 32'd1 : 32'd0);
      if (we && !e_er) begin
        chk("mem_din", wdin, e_din);
        chk("mem_addr", {20'b0, wadr}, {20'b0, e_wadr});
      end
      @(negedge clk);
      chk("resp_pulse", {31'b0, resp_valid}, 32'd0);
      chk("resp_hold", resp_rdata, e_rd);
    end
  endtask

  initial begin
    logic [31:0] m_rd, m_din, ra, rw;
    logic m_er, rwe, run;
    logic [1:0] rsz;
    logic [11:0] m_idx;
    int m_lat, seen;
    rst = 1; clr = 1;
    req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
    for (int i = 0; i < 4096; i++) model[i] = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'b0, resp_err}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", {20'b0, mem_addr}, 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    rst = 0; clr = 0;

    tv[0]  = '{1, 2'd2, 0, 32'h10,   32'h80FF7F01, 32'h0,        0, 2, 32'h80FF7F01, 12'd4};
    tv[1]  = '{0, 2'd0, 0, 32'h13,   32'h0,        32'hFFFFFF80, 0, 3, 32'h0, 12'd0};
    tv[2]  = '{0, 2'd0, 1, 32'h13,   32'h0,        32'h00000080, 0, 3, 32'h0, 12'd0};
    tv[3]  = '{0, 2'd1, 0, 32'h12,   32'h0,        32'hFFFF80FF, 0, 3, 32'h0, 12'd0};
    tv[4]  = '{0, 2'd2, 0, 32'h10,   32'h0,        32'h80FF7F01, 0, 3, 32'h0, 12'd0};
    tv[5]  = '{1, 2'd0, 0, 32'h11,   32'h123456AA, 32'h0,        0, 4, 32'h80FFAA01, 12'd4};
    tv[6]  = '{0, 2'd2, 0, 32'h10,   32'h0,        32'h80FFAA01, 0, 3, 32'h0, 12'd0};
    tv[7]  = '{0, 2'd1, 0, 32'h11,   32'h0,        32'h0,        1, 1, 32'h0, 12'd0};
    tv[8]  = '{1, 2'd2, 0, 32'h12,   32'hDEADBEEF, 32'h0,        1, 1, 32'h0, 12'd0};
    tv[9]  = '{0, 2'd3, 0, 32'h10,   32'h0,        32'h0,        1, 1, 32'h0, 12'd0};
    tv[10] = '{1, 2'd3, 0, 32'h10,   32'hFFFFFFFF, 32'h0,        1, 1, 32'h0, 12'd0};
    tv[11] = '{0, 2'd2, 0, 32'h10,   32'h0,        32'h80FFAA01, 0, 3, 32'h0, 12'd0};
    tv[12] = '{1, 2'd2, 0, 32'h4000, 32'h12345678, 32'h0,        0, 2, 32'h12345678, 12'd0};
    tv[13] = '{0, 2'd2, 0, 32'h0,    32'h0,        32'h12345678, 0, 3, 32'h0, 12'd0};
    tv[14] = '{1, 2'd1, 0, 32'h16,   32'hCAFEBEEF, 32'h0,        0, 4, 32'hBEEF0000, 12'd5};
    tv[15] = '{0, 2'd1, 1, 32'h16,   32'h0,        32'h0000BEEF, 0, 3, 32'h0, 12'd0};
    tv[16] = '{0, 2'd1, 0, 32'h16,   32'h0,        32'hFFFFBEEF, 0, 3, 32'h0, 12'd0};
    tv[17] = '{0, 2'd0, 0, 32'h14,   32'h0,        32'h00000000, 0, 3, 32'h0, 12'd0};
    for (int i = 0; i < 18; i++) begin
      model_step(tv[i].we, tv[i].sz, tv[i].un, tv[i].a, tv[i].wd, m_rd, m_er, m_lat, m_din, m_idx);
      do_txn(tv[i].we, tv[i].sz, tv[i].un, tv[i].a, tv[i].wd,
             tv[i].rd, tv[i].er, tv[i].lat, tv[i].din, tv[i].wadr);
    end

    // reset lands on the write cycle of a byte store: no write, no response
    @(negedge clk);
    req_valid = 1; req_we = 1; req_size = 2'd0; req_unsigned = 0; req_addr = 32'h21; req_wdata = 32'h55;
    @(negedge clk);
    req_valid = 0;
    chk("rmw_no_early_we", {31'b0, mem_we}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1;
    #1;
    chk("rst_wr_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_wr_resp", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_drop_ready", {31'b0, req_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid || mem_we) seen++;
      @(negedge clk);
    end
    chk("rst_no_resp", seen, 32'd0);
    model_step(0, 2'd2, 0, 32'h20, 32'h0, m_rd, m_er, m_lat, m_din, m_idx);
    do_txn(0, 2'd2, 0, 32'h20, 32'h0, m_rd, m_er, m_lat, m_din, m_idx);

    for (int n = 0; n < 300; n++) begin
      rwe = 1'($urandom);
      rsz = 2'($urandom_range(0, 3));
      run = 1'($urandom);
      ra = $urandom_range(0, 63);
      if ($urandom_range(0, 3) == 0) ra = ra | ($urandom & 32'hFFFF_C000);
      if ($urandom_range(0, 3) != 0 && rsz != 2'd3) ra = ra & ~((32'h1 << rsz) - 1);
      rw = $urandom;
      model_step(rwe, rsz, run, ra, rw, m_rd, m_er, m_lat, m_din, m_idx);
      do_txn(rwe, rsz, run, ra, rw, m_rd, m_er, m_lat, m_din, m_idx);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
